// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback stage: load funct3 codes, the
// writeback FSM state type and RV32 load-data extraction.
package wb_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_CNN = 1'b1
  } wb_state_t;

  // Any funct3 outside the four sub-word loads returns the word untouched.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0]  funct3,
                                               input logic [1:0]  addr_lo);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*addr_lo +: 8];
    h = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_LB:   load_extract = {{24{b[7]}}, b};
      F3_LH:   load_extract = {{16{h[15]}}, h};
      F3_LBU:  load_extract = {24'd0, b};
      F3_LHU:  load_extract = {16'd0, h};
      default: load_extract = word;
    endcase
  endfunction

endpackage

// File: rtl/cnn_result_fifo.sv
// Small synchronous FIFO holding accelerator results with show-ahead head
// data. Full blocks pushes even when a pop happens in the same cycle.
module cnn_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [LVL_W-1:0] cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == LVL_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign level   = cnt_q;
  assign head    = mem_q[rptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_W'(1);
      if (do_pop)  rptr_q <= rptr_q + PTR_W'(1);
      cnt_q <= cnt_q + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: retires MEM-stage instructions, extracts load data and
// merges asynchronously returned CNN accelerator results into the RF port.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_W     = 5,
  parameter int CNN_FIFO_DEPTH = 4,
  parameter int CNT_W          = 32,
  parameter int LVL_W          = $clog2(CNN_FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]       mem_val,
  input  logic                  mem_is_load,
  input  logic [2:0]            mem_funct3,
  input  logic [1:0]            mem_addr_lo,
  input  logic                  mem_is_cnn,
  input  logic                  cnn_valid,
  output logic                  cnn_ready,
  input  logic [XLEN-1:0]       cnn_data,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  wb_valid,
  output logic [LVL_W-1:0]      cnn_level,
  output logic [CNT_W-1:0]      retire_count,
  output wb_state_t             dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // ready never depends on valid on either interface.

  wb_state_t             state_q;
  logic [REG_ADDR_W-1:0] pend_rd_q;
  logic                  rf_we_q, wb_valid_q;
  logic [REG_ADDR_W-1:0] rf_waddr_q;
  logic [XLEN-1:0]       rf_wdata_q;
  logic [CNT_W-1:0]      cnt_q;

  logic                  accept, fifo_pop, fifo_full, fifo_empty;
  logic [XLEN-1:0]       fifo_head;
  logic                  retire_d;
  logic [REG_ADDR_W-1:0] rd_d;
  logic [XLEN-1:0]       data_d;

  assign mem_ready = (state_q == IDLE);
  assign cnn_ready = !fifo_full;
  assign accept    = mem_valid && mem_ready;

  cnn_result_fifo #(
    .DEPTH (CNN_FIFO_DEPTH),
    .WIDTH (XLEN),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (cnn_valid),
    .push_data (cnn_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (cnn_level)
  );

  // Retire selection; the CNN flag overrides load extraction.
  always_comb begin
    fifo_pop = 1'b0;
    retire_d = 1'b0;
    rd_d     = mem_rd;
    data_d   = mem_is_load ? load_extract(mem_val, mem_funct3, mem_addr_lo) : mem_val;
    if (state_q == IDLE) begin
      if (accept && mem_is_cnn) begin
        fifo_pop = !fifo_empty;
        retire_d = !fifo_empty;
        data_d   = fifo_head;
      end else if (accept) begin
        retire_d = 1'b1;
      end
    end else if (!fifo_empty) begin
      fifo_pop = 1'b1;
      retire_d = 1'b1;
      rd_d     = pend_rd_q;
      data_d   = fifo_head;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pend_rd_q  <= '0;
      rf_we_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      cnt_q      <= '0;
    end else begin
      wb_valid_q <= retire_d;
      rf_we_q    <= retire_d && (rd_d != '0);
      if (retire_d) begin
        rf_waddr_q <= rd_d;
        rf_wdata_q <= data_d;
        cnt_q      <= cnt_q + CNT_W'(1);
      end
      unique case (state_q)
        IDLE: begin
          if (accept && mem_is_cnn && fifo_empty) begin
            pend_rd_q <= mem_rd;
            state_q   <= WAIT_CNN;
          end
        end
        WAIT_CNN: begin
          if (!fifo_empty) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rf_we        = rf_we_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign wb_valid     = wb_valid_q;
  assign retire_count = cnt_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: load extraction, x0 suppression,
// CNN miss/hit, FIFO full back-pressure and reset while waiting.
module tb_writeback_unit;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_valid, mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_val;
  logic        mem_is_load;
  logic [2:0]  mem_funct3;
  logic [1:0]  mem_addr_lo;
  logic        mem_is_cnn;
  logic        cnn_valid, cnn_ready;
  logic [31:0] cnn_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_valid;
  logic [2:0]  cnn_level;
  logic [31:0] retire_count;
  wb_state_t   dbg_state;

  int vectors    = 0;
  int miscompares = 0;
  int exp_count  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  logic [4:0]  rd_list [8] = '{5'd3, 5'd4, 5'd5, 5'd0, 5'd6, 5'd7, 5'd8, 5'd9};

  writeback_unit dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_rd       (mem_rd),
    .mem_val      (mem_val),
    .mem_is_load  (mem_is_load),
    .mem_funct3   (mem_funct3),
    .mem_addr_lo  (mem_addr_lo),
    .mem_is_cnn   (mem_is_cnn),
    .cnn_valid    (cnn_valid),
    .cnn_ready    (cnn_ready),
    .cnn_data     (cnn_data),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .wb_valid     (wb_valid),
    .cnn_level    (cnn_level),
    .retire_count (retire_count),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_mem(input logic v, input logic [4:0] rd, input logic [31:0] val,
                           input logic ld, input logic [2:0] f3, input logic [1:0] lo,
                           input logic cnn);
    mem_valid   = v;
    mem_rd      = rd;
    mem_val     = val;
    mem_is_load = ld;
    mem_funct3  = f3;
    mem_addr_lo = lo;
    mem_is_cnn  = cnn;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rf_we"},    32'(rf_we), 32'd0);
    chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
  endtask

  initial begin
    // Reset
    reset_n = 1'b0;
    drive_mem(1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0, 1'b0);
    cnn_valid = 1'b0;
    cnn_data  = 32'd0;
    tick(); tick();
    chk("rst_mem_ready", 32'(mem_ready), 32'd1);
    chk("rst_cnn_ready", 32'(cnn_ready), 32'd1);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_count", retire_count, 32'd0);
    chk("rst_level", 32'(cnn_level), 32'd0);
    reset_n = 1'b1;
    tick();

    // Load extraction on 0x80FF7F01
    drive_mem(1'b1, 5'd1, 32'h80FF7F01, 1'b1, F3_LB, 2'd3, 1'b0);
    tick(); exp_count++;
    chk("lb3_data", rf_wdata, 32'hFFFFFF80);
    chk("lb3_we", 32'(rf_we), 32'd1);
    chk("lb3_addr", 32'(rf_waddr), 32'd1);
    drive_mem(1'b1, 5'd2, 32'h80FF7F01, 1'b1, F3_LBU, 2'd1, 1'b0);
    tick(); exp_count++;
    chk("lbu1_data", rf_wdata, 32'h0000007F);
    drive_mem(1'b1, 5'd3, 32'h80FF7F01, 1'b1, F3_LH, 2'd2, 1'b0);
    tick(); exp_count++;
    chk("lh2_data", rf_wdata, 32'hFFFF80FF);
    drive_mem(1'b1, 5'd4, 32'h80FF7F01, 1'b1, F3_LHU, 2'd0, 1'b0);
    tick(); exp_count++;
    chk("lhu0_data", rf_wdata, 32'h00007F01);
    drive_mem(1'b1, 5'd5, 32'h80FF7F01, 1'b1, F3_LW, 2'd3, 1'b0);
    tick(); exp_count++;
    chk("lw_data", rf_wdata, 32'h80FF7F01);
    drive_mem(1'b1, 5'd6, 32'h12345678, 1'b0, F3_LB, 2'd1, 1'b0);
    tick(); exp_count++;
    chk("alu_noext", rf_wdata, 32'h12345678);
    drive_mem(1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0, 1'b0);
    tick();
    chk_idle_outputs("load_done");
    chk("load_count", retire_count, 32'(exp_count));

    // Eight back-to-back ALU retires, one to x0
    for (int i = 0; i < 8; i++) begin
      drive_mem(1'b1, rd_list[i], 32'h1000 + 32'(i), 1'b0, 3'd0, 2'd0, 1'b0);
      tick(); exp_count++;
      chk("b2b_we", 32'(rf_we), (rd_list[i] != 5'd0) ? 32'd1 : 32'd0);
      chk("b2b_valid", 32'(wb_valid), 32'd1);
      chk("b2b_data", rf_wdata, 32'h1000 + 32'(i));
    end
    drive_mem(1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0, 1'b0);
    tick();
    chk("b2b_count", retire_count, 32'(exp_count));

    // CNN miss: rd=10, result arrives three cycles later
    drive_mem(1'b1, 5'd10, 32'hDEADBEEF, 1'b0, 3'd0, 2'd0, 1'b1);
    tick();
    drive_mem(1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0, 1'b0);
    chk("miss_ready", 32'(mem_ready), 32'd0);
    chk("miss_state", 32'(dbg_state), 32'(WAIT_CNN));
    chk_idle_outputs("miss_wait0");
    tick(); tick();
    chk("miss_ready2", 32'(mem_ready), 32'd0);
    chk_idle_outputs("miss_wait2");
    cnn_valid = 1'b1;
    cnn_data  = 32'h00000003;
    tick();
    cnn_valid = 1'b0;
    chk("miss_push_level", 32'(cnn_level), 32'd1);
    chk_idle_outputs("miss_nobypass");
    tick(); exp_count++;
    chk("miss_we", 32'(rf_we), 32'd1);
    chk("miss_addr", 32'(rf_waddr), 32'd10);
    chk("miss_data", rf_wdata, 32'd3);
    chk("miss_valid", 32'(wb_valid), 32'd1);
    chk("miss_ready_back", 32'(mem_ready), 32'd1);
    chk("miss_level0", 32'(cnn_level), 32'd0);

    // Fill the FIFO with no consumer
    for (int i = 0; i < 4; i++) begin
      cnn_valid = 1'b1;
      cnn_data  = 32'h100 + 32'(i);
      chk("fill_ready", 32'(cnn_ready), 32'd1);
      exp_q.push_back(cnn_data);
      tick();
    end
    chk("full_level", 32'(cnn_level), 32'd4);
    chk("full_ready", 32'(cnn_ready), 32'd0);
    cnn_data = 32'h104;
    tick();
    chk("full_hold_level", 32'(cnn_level), 32'd4);
    // Hit while full: the held 5th push must still be refused this edge
    drive_mem(1'b1, 5'd11, 32'd0, 1'b0, 3'd0, 2'd0, 1'b1);
    tick(); exp_count++;
    exp_v = exp_q.pop_front();
    chk("hit_data", rf_wdata, exp_v);
    chk("hit_addr", 32'(rf_waddr), 32'd11);
    chk("hit_level", 32'(cnn_level), 32'd3);
    chk("hit_ready", 32'(mem_ready), 32'd1);
    drive_mem(1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0, 1'b0);
    exp_q.push_back(cnn_data);
    tick();
    cnn_valid = 1'b0;
    chk("fifth_level", 32'(cnn_level), 32'd4);
    for (int i = 0; i < 4; i++) begin
      drive_mem(1'b1, 5'(12 + i), 32'd0, 1'b0, 3'd0, 2'd0, 1'b1);
      tick(); exp_count++;
      exp_v = exp_q.pop_front();
      chk("drain_data", rf_wdata, exp_v);
      chk("drain_we", 32'(rf_we), 32'd1);
    end
    drive_mem(1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0, 1'b0);
    tick();
    chk("drain_level", 32'(cnn_level), 32'd0);
    chk("drain_count", retire_count, 32'(exp_count));

    // Reset while waiting for a CNN result
    drive_mem(1'b1, 5'd7, 32'd0, 1'b0, 3'd0, 2'd0, 1'b1);
    tick();
    drive_mem(1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0, 1'b0);
    chk("rw_ready", 32'(mem_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("rw_mem_ready", 32'(mem_ready), 32'd1);
    chk("rw_cnn_ready", 32'(cnn_ready), 32'd1);
    chk("rw_rf_wdata", rf_wdata, 32'd0);
    chk("rw_rf_waddr", 32'(rf_waddr), 32'd0);
    chk("rw_count", retire_count, 32'd0);
    chk("rw_level", 32'(cnn_level), 32'd0);
    chk_idle_outputs("rw_rst");
    tick();
    reset_n = 1'b1;
    tick();
    cnn_valid = 1'b1;
    cnn_data  = 32'h55;
    tick();
    cnn_valid = 1'b0;
    tick();
    chk_idle_outputs("rw_no_pend");
    chk("rw_level1", 32'(cnn_level), 32'd1);
    chk("rw_count0", retire_count, 32'd0);
    drive_mem(1'b1, 5'd9, 32'd0, 1'b0, 3'd0, 2'd0, 1'b1);
    tick();
    drive_mem(1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0, 1'b0);
    chk("rw_hit_data", rf_wdata, 32'h55);
    chk("rw_hit_addr", 32'(rf_waddr), 32'd9);
    chk("rw_count1", retire_count, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
